// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and constants for the IPM issue controller
package ibex_pkg;

  // Default watchdog limit, in stalled cycles, for an in-flight IPM op
  localparam int unsigned IpmTimeoutDefault = 64;

  // Decoded IPM operator; zero is the idle/reset encoding
  typedef enum logic [1:0] {
    IPM_OP_NONE = 2'd0,
    IPM_OP_DOT  = 2'd1,
    IPM_OP_MAC  = 2'd2,
    IPM_OP_POW  = 2'd3
  } ipm_op_e;

  // Issue FSM states
  typedef enum logic [1:0] {
    IPM_IDLE    = 2'd0,
    IPM_BUSY    = 2'd1,
    IPM_WAIT_WB = 2'd2
  } ipm_issue_state_e;

endpackage

// File: rtl/ibex_ipm_issue_ctrl.sv
// rtl/ibex_ipm_issue_ctrl.sv - IPM issue/stall/writeback control; watchdog under IBEX_IPM_TIMEOUT_EN
module ibex_ipm_issue_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned TimeoutCycles = IpmTimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic        ipm_instr_i,
  input  ipm_op_e     ipm_op_i,
  input  logic        instr_kill_i,
  input  logic        ex_valid_i,
  input  logic [31:0] result_ex_i,
  input  logic        ready_wb_i,
  output logic        ipm_sel_o,
  output logic        ipm_en_o,
  output ipm_op_e     ipm_operator_o,
  output logic        ipm_ready_id_o,
  output logic        stall_ipm_o,
  output logic        rf_we_o,
  output logic [31:0] rf_wdata_o,
  output logic        ipm_err_o
);

  ipm_issue_state_e r_state;
  ipm_issue_state_e w_state_next;
  ipm_op_e          r_op;
  logic [31:0]      r_result;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_sat;

  logic w_sel;
  logic w_en;
  logic w_we;
  logic w_ready_id;
  logic w_stall;
  logic w_err;
  logic w_capture;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_timeout;

  assign w_sel     = instr_valid_i & ipm_instr_i;
  assign w_cnt_sat = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

`ifdef IBEX_IPM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);
  // Abort on the BUSY cycle whose increment would bring the counter to the limit
  assign w_timeout = (r_state == IPM_BUSY) & (w_cnt_sat == TimeoutLast);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TimeoutCycles;
  assign w_timeout        = 1'b0;
`endif

  // Next-state and control decode; kill dominates every other condition
  always_comb begin
    w_state_next = r_state;
    w_en         = 1'b0;
    w_we         = 1'b0;
    w_ready_id   = 1'b0;
    w_stall      = 1'b0;
    w_err        = 1'b0;
    w_capture    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      IPM_IDLE, IPM_BUSY: begin
        if (instr_kill_i || !w_sel) begin
          w_state_next = IPM_IDLE;
        end else if (!ex_valid_i && w_timeout) begin
          w_err        = 1'b1;
          w_state_next = IPM_IDLE;
        end else begin
          w_en = 1'b1;
          if (ex_valid_i && ready_wb_i) begin
            w_we         = 1'b1;
            w_ready_id   = 1'b1;
            w_state_next = IPM_IDLE;
          end else if (ex_valid_i) begin
            w_capture    = 1'b1;
            w_stall      = 1'b1;
            w_state_next = IPM_WAIT_WB;
          end else begin
            w_stall      = 1'b1;
            w_state_next = IPM_BUSY;
            w_cnt_clr    = (r_state == IPM_IDLE);
            w_cnt_inc    = (r_state == IPM_BUSY);
          end
        end
      end
      IPM_WAIT_WB: begin
        if (instr_kill_i) begin
          w_state_next = IPM_IDLE;
        end else begin
          w_stall = ~ready_wb_i;
          if (ready_wb_i) begin
            w_we         = 1'b1;
            w_ready_id   = 1'b1;
            w_state_next = IPM_IDLE;
          end
        end
      end
      default: w_state_next = IPM_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IPM_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operator latch, parked result and busy counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= IPM_OP_NONE;
      r_result <= 32'd0;
      r_cnt    <= 8'd0;
    end else begin
      if (r_state == IPM_IDLE && w_state_next != IPM_IDLE) begin
        r_op <= ipm_op_i;
      end
      if (w_capture) begin
        r_result <= result_ex_i;
      end
      if (w_cnt_clr) begin
        r_cnt <= 8'd0;
      end else if (w_cnt_inc) begin
        r_cnt <= w_cnt_sat;
      end
    end
  end

  // Outputs are forced low while reset is held so an abandoned op cannot leak out
  assign ipm_sel_o      = w_sel & rst_ni;
  assign ipm_en_o       = w_en & rst_ni;
  assign ipm_operator_o = !rst_ni ? IPM_OP_NONE : (r_state == IPM_IDLE) ? ipm_op_i : r_op;
  assign ipm_ready_id_o = w_ready_id & rst_ni;
  assign stall_ipm_o    = w_stall & rst_ni;
  assign rf_we_o        = w_we & rst_ni;
  assign rf_wdata_o     = !rst_ni ? 32'd0 : (r_state == IPM_WAIT_WB) ? r_result : result_ex_i;
  assign ipm_err_o      = w_err & rst_ni;

endmodule

// File: tb/tb_ibex_ipm_issue_ctrl.sv
// tb/tb_ibex_ipm_issue_ctrl.sv - directed self-checking bench for ibex_ipm_issue_ctrl
module tb_ibex_ipm_issue_ctrl;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_valid_i;
  logic        ipm_instr_i;
  ipm_op_e     ipm_op_i;
  logic        instr_kill_i;
  logic        ex_valid_i;
  logic [31:0] result_ex_i;
  logic        ready_wb_i;
  logic        ipm_sel_o;
  logic        ipm_en_o;
  ipm_op_e     ipm_operator_o;
  logic        ipm_ready_id_o;
  logic        stall_ipm_o;
  logic        rf_we_o;
  logic [31:0] rf_wdata_o;
  logic        ipm_err_o;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int w0;

  always #5 clk = ~clk;

  ibex_ipm_issue_ctrl #(.TimeoutCycles(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_valid_i  (instr_valid_i),
    .ipm_instr_i    (ipm_instr_i),
    .ipm_op_i       (ipm_op_i),
    .instr_kill_i   (instr_kill_i),
    .ex_valid_i     (ex_valid_i),
    .result_ex_i    (result_ex_i),
    .ready_wb_i     (ready_wb_i),
    .ipm_sel_o      (ipm_sel_o),
    .ipm_en_o       (ipm_en_o),
    .ipm_operator_o (ipm_operator_o),
    .ipm_ready_id_o (ipm_ready_id_o),
    .stall_ipm_o    (stall_ipm_o),
    .rf_we_o        (rf_we_o),
    .rf_wdata_o     (rf_wdata_o),
    .ipm_err_o      (ipm_err_o)
  );

  // Count register-file writes mid-cycle
  always @(negedge clk) begin
    if (rf_we_o) n_writes++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    instr_valid_i = 1'b0;
    ipm_instr_i   = 1'b0;
    ipm_op_i      = IPM_OP_NONE;
    instr_kill_i  = 1'b0;
    ex_valid_i    = 1'b0;
    result_ex_i   = 32'd0;
    ready_wb_i    = 1'b0;
  endtask

  task automatic issue(input ipm_op_e op, input logic exv, input logic rdy, input logic [31:0] res);
    instr_valid_i = 1'b1;
    ipm_instr_i   = 1'b1;
    ipm_op_i      = op;
    ex_valid_i    = exv;
    ready_wb_i    = rdy;
    result_ex_i   = res;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    settle();
    check("rst_sel",   ipm_sel_o, 0);
    check("rst_en",    ipm_en_o, 0);
    check("rst_stall", stall_ipm_o, 0);
    check("rst_we",    rf_we_o, 0);
    check("rst_err",   ipm_err_o, 0);
    check("rst_rdy",   ipm_ready_id_o, 0);
    rst_ni = 1'b1;
    tick();

    // zero-wait completion
    w0 = n_writes;
    issue(IPM_OP_DOT, 1'b1, 1'b1, 32'h1234_5678);
    settle();
    check("zw_we",    rf_we_o, 1);
    check("zw_wdata", rf_wdata_o, 32'h1234_5678);
    check("zw_rdy",   ipm_ready_id_o, 1);
    check("zw_stall", stall_ipm_o, 0);
    check("zw_sel",   ipm_sel_o, 1);
    tick();
    idle_inputs();
    settle();
    check("zw_we_after", rf_we_o, 0);
    check("zw_nwrites", n_writes - w0, 1);
    tick();

    // ex_valid after 5 stall cycles, operator held from issue
    w0 = n_writes;
    issue(IPM_OP_MAC, 1'b0, 1'b1, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      settle();
      check("busy_stall", stall_ipm_o, 1);
      check("busy_op",    ipm_operator_o, IPM_OP_MAC);
      check("busy_we",    rf_we_o, 0);
      tick();
      if (i == 1) ipm_op_i = IPM_OP_POW;
    end
    ex_valid_i  = 1'b1;
    result_ex_i = 32'hCAFE_0006;
    settle();
    check("busy_done_we",    rf_we_o, 1);
    check("busy_done_wdata", rf_wdata_o, 32'hCAFE_0006);
    check("busy_done_stall", stall_ipm_o, 0);
    check("busy_done_op",    ipm_operator_o, IPM_OP_MAC);
    check("busy_done_rdy",   ipm_ready_id_o, 1);
    tick();
    idle_inputs();
    settle();
    check("busy_we_after", rf_we_o, 0);
    tick();
    check("busy_nwrites", n_writes - w0, 1);

    // writeback back-pressure for 3 cycles
    w0 = n_writes;
    issue(IPM_OP_DOT, 1'b1, 1'b0, 32'hDEAD_BEEF);
    settle();
    check("wb_c1_en",    ipm_en_o, 1);
    check("wb_c1_stall", stall_ipm_o, 1);
    check("wb_c1_we",    rf_we_o, 0);
    tick();
    ex_valid_i  = 1'b0;
    result_ex_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("wb_wait_en",    ipm_en_o, 0);
      check("wb_wait_stall", stall_ipm_o, 1);
      check("wb_wait_we",    rf_we_o, 0);
      tick();
    end
    ready_wb_i = 1'b1;
    settle();
    check("wb_we",    rf_we_o, 1);
    check("wb_wdata", rf_wdata_o, 32'hDEAD_BEEF);
    check("wb_stall", stall_ipm_o, 0);
    check("wb_rdy",   ipm_ready_id_o, 1);
    tick();
    idle_inputs();
    settle();
    check("wb_we_after", rf_we_o, 0);
    tick();
    check("wb_nwrites", n_writes - w0, 1);

    // kill in BUSY coincident with ex_valid
    w0 = n_writes;
    issue(IPM_OP_MAC, 1'b0, 1'b1, 32'h0);
    settle();
    check("kill_busy_stall", stall_ipm_o, 1);
    tick();
    instr_kill_i = 1'b1;
    ex_valid_i   = 1'b1;
    result_ex_i  = 32'hBAD0_BAD0;
    settle();
    check("kill_we",    rf_we_o, 0);
    check("kill_rdy",   ipm_ready_id_o, 0);
    check("kill_stall", stall_ipm_o, 0);
    check("kill_en",    ipm_en_o, 0);
    tick();
    instr_kill_i = 1'b0;
    ipm_op_i     = IPM_OP_POW;
    result_ex_i  = 32'h600D_600D;
    settle();
    check("kill_next_op",    ipm_operator_o, IPM_OP_POW);
    check("kill_next_we",    rf_we_o, 1);
    check("kill_next_wdata", rf_wdata_o, 32'h600D_600D);
    tick();
    idle_inputs();
    tick();
    check("kill_nwrites", n_writes - w0, 1);

    // watchdog: ex_valid never arrives
    w0 = n_writes;
    issue(IPM_OP_DOT, 1'b0, 1'b1, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      settle();
      check("wd_err_low", ipm_err_o, 0);
      check("wd_stall",   stall_ipm_o, 1);
      tick();
    end
    settle();
`ifdef IBEX_IPM_TIMEOUT_EN
    check("wd_err_pulse", ipm_err_o, 1);
    check("wd_err_en",    ipm_en_o, 0);
    check("wd_err_we",    rf_we_o, 0);
`else
    check("wd_no_err",   ipm_err_o, 0);
    check("wd_no_stall", stall_ipm_o, 1);
`endif
    tick();
    ipm_op_i = IPM_OP_MAC;
    settle();
    check("wd_err_after", ipm_err_o, 0);
`ifdef IBEX_IPM_TIMEOUT_EN
    check("wd_idle_op", ipm_operator_o, IPM_OP_MAC);
`else
    check("wd_busy_op", ipm_operator_o, IPM_OP_DOT);
`endif
    tick();
    instr_valid_i = 1'b0;
    settle();
    check("wd_vanish_stall", stall_ipm_o, 0);
    check("wd_vanish_we",    rf_we_o, 0);
    tick();
    idle_inputs();
    check("wd_nwrites", n_writes - w0, 0);

    // reset asserted while BUSY
    w0 = n_writes;
    issue(IPM_OP_POW, 1'b0, 1'b1, 32'h0000_5555);
    tick();
    settle();
    check("rb_busy_stall", stall_ipm_o, 1);
    rst_ni = 1'b0;
    #1;
    check("rb_sel",   ipm_sel_o, 0);
    check("rb_en",    ipm_en_o, 0);
    check("rb_stall", stall_ipm_o, 0);
    check("rb_we",    rf_we_o, 0);
    check("rb_wdata", rf_wdata_o, 0);
    check("rb_rdy",   ipm_ready_id_o, 0);
    check("rb_err",   ipm_err_o, 0);
    tick();
    tick();
    rst_ni      = 1'b1;
    ipm_op_i    = IPM_OP_DOT;
    ex_valid_i  = 1'b1;
    result_ex_i = 32'h0000_ABCD;
    settle();
    check("rb_idle_op",   ipm_operator_o, IPM_OP_DOT);
    check("rb_new_we",    rf_we_o, 1);
    check("rb_new_wdata", rf_wdata_o, 32'h0000_ABCD);
    tick();
    idle_inputs();
    tick();
    check("rb_nwrites", n_writes - w0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
